// File: rtl/sc_reg_point_multi.sv
// Multi-channel one-hot position register with per-channel tick prescaler,
// travel limits, OR-merged display output and registered overlap flag.
module sc_reg_point_multi #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned STEP_DIV  = 2,
  parameter logic [CHANNELS*DATAWIDTH-1:0] INIT_VEC        = {8'h01, 8'h10},
  parameter logic [CHANNELS*DATAWIDTH-1:0] LEFT_LIMIT_VEC  = {8'h08, 8'h80},
  parameter logic [CHANNELS*DATAWIDTH-1:0] RIGHT_LIMIT_VEC = {8'h01, 8'h10}
) (
  input  logic                            SC_RegPOINTMULTI_CLOCK_50,
  input  logic                            SC_RegPOINTMULTI_RESET_InLow,
  input  logic [CHANNELS-1:0]             SC_RegPOINTMULTI_clear_InLow,
  input  logic [CHANNELS-1:0]             SC_RegPOINTMULTI_load_InLow,
  input  logic [DATAWIDTH-1:0]            SC_RegPOINTMULTI_data_InBUS,
  input  logic [2*CHANNELS-1:0]           SC_RegPOINTMULTI_shiftselection_In,
  input  logic                            SC_RegPOINTMULTI_tick_In,
  output logic [DATAWIDTH-1:0]            SC_RegPOINTMULTI_data_OutBUS,
  output logic [CHANNELS*DATAWIDTH-1:0]   SC_RegPOINTMULTI_channel_OutBUS,
  output logic [CHANNELS-1:0]             SC_RegPOINTMULTI_atLimit_Out,
  output logic                            SC_RegPOINTMULTI_overlap_Out
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  logic clk;
  logic rst_n;
  logic [CHANNELS*DATAWIDTH-1:0] chan_flat;
  logic overlap_nxt;

  assign clk   = SC_RegPOINTMULTI_CLOCK_50;
  assign rst_n = SC_RegPOINTMULTI_RESET_InLow;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [DATAWIDTH-1:0] pos_q, pos_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [1:0]           last_dir_q;
    logic [1:0]           dir;
    logic [DATAWIDTH-1:0] left_lim, right_lim;
    logic                 blocked;

    assign dir       = SC_RegPOINTMULTI_shiftselection_In[2*c +: 2];
    assign left_lim  = LEFT_LIMIT_VEC[c*DATAWIDTH +: DATAWIDTH];
    assign right_lim = RIGHT_LIMIT_VEC[c*DATAWIDTH +: DATAWIDTH];
    assign blocked   = (dir == DIR_LEFT) ? (pos_q == left_lim) : (pos_q == right_lim);

    // Priority: clear > load > prescaled move > hold
    always_comb begin
      pos_nxt = pos_q;
      cnt_nxt = cnt_q;
      if (!SC_RegPOINTMULTI_clear_InLow[c]) begin
        pos_nxt = INIT_VEC[c*DATAWIDTH +: DATAWIDTH];
        cnt_nxt = '0;
      end else if (!SC_RegPOINTMULTI_load_InLow[c]) begin
        pos_nxt = SC_RegPOINTMULTI_data_InBUS;
        cnt_nxt = '0;
      end else if ((dir != DIR_LEFT && dir != DIR_RIGHT) || dir != last_dir_q) begin
        cnt_nxt = '0;
      end else if (SC_RegPOINTMULTI_tick_In) begin
        if (cnt_q == CNT_LAST) begin
          cnt_nxt = '0;
          if (!blocked) begin
            pos_nxt = (dir == DIR_LEFT) ? {pos_q[DATAWIDTH-2:0], pos_q[DATAWIDTH-1]}
                                        : {pos_q[0], pos_q[DATAWIDTH-1:1]};
          end
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
    end

    // last_dir simply follows the request so a change is seen exactly once
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pos_q      <= '0;
        cnt_q      <= '0;
        last_dir_q <= 2'b00;
      end else begin
        pos_q      <= pos_nxt;
        cnt_q      <= cnt_nxt;
        last_dir_q <= dir;
      end
    end

    assign chan_flat[c*DATAWIDTH +: DATAWIDTH] = pos_q;
    assign SC_RegPOINTMULTI_atLimit_Out[c] = (pos_q == left_lim) || (pos_q == right_lim);
  end

  assign SC_RegPOINTMULTI_channel_OutBUS = chan_flat;

  // Merged display pattern and pairwise collision detect
  always_comb begin
    SC_RegPOINTMULTI_data_OutBUS = '0;
    overlap_nxt = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      SC_RegPOINTMULTI_data_OutBUS = SC_RegPOINTMULTI_data_OutBUS
                                     | chan_flat[i*DATAWIDTH +: DATAWIDTH];
      for (int unsigned j = i + 1; j < CHANNELS; j++) begin
        if (|(chan_flat[i*DATAWIDTH +: DATAWIDTH] & chan_flat[j*DATAWIDTH +: DATAWIDTH]))
          overlap_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) SC_RegPOINTMULTI_overlap_Out <= 1'b0;
    else        SC_RegPOINTMULTI_overlap_Out <= overlap_nxt;
  end

endmodule

// File: tb/tb_sc_reg_point_multi.sv
// Directed self-checking bench for sc_reg_point_multi (default parameters).
module tb_sc_reg_point_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  clear_n;
  logic [1:0]  load_n;
  logic [7:0]  data_in;
  logic [3:0]  dir;
  logic        tick;
  logic [7:0]  data_out;
  logic [15:0] chan_out;
  logic [1:0]  at_limit;
  logic        overlap;

  int checks   = 0;
  int failures = 0;

  sc_reg_point_multi dut (
    .SC_RegPOINTMULTI_CLOCK_50          (clk),
    .SC_RegPOINTMULTI_RESET_InLow       (rst_n),
    .SC_RegPOINTMULTI_clear_InLow       (clear_n),
    .SC_RegPOINTMULTI_load_InLow        (load_n),
    .SC_RegPOINTMULTI_data_InBUS        (data_in),
    .SC_RegPOINTMULTI_shiftselection_In (dir),
    .SC_RegPOINTMULTI_tick_In           (tick),
    .SC_RegPOINTMULTI_data_OutBUS       (data_out),
    .SC_RegPOINTMULTI_channel_OutBUS    (chan_out),
    .SC_RegPOINTMULTI_atLimit_Out       (at_limit),
    .SC_RegPOINTMULTI_overlap_Out       (overlap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  logic [7:0] ch0_exp [8] = '{8'h10, 8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80};

  initial begin
    rst_n = 1'b0; clear_n = 2'b11; load_n = 2'b11; data_in = 8'h00; dir = 4'b0000; tick = 1'b0;
    step(); step();
    check_eq("rst_chan", 32'(chan_out), 32'h0);
    check_eq("rst_data", 32'(data_out), 32'h0);
    check_eq("rst_lim",  32'(at_limit), 32'h0);
    check_eq("rst_ovl",  32'(overlap),  32'h0);
    rst_n = 1'b1;
    step();

    // Clear both channels to their init values
    clear_n = 2'b00; step(); clear_n = 2'b11;
    check_eq("clr_chan", 32'(chan_out), 32'h0110);
    check_eq("clr_data", 32'(data_out), 32'h11);
    check_eq("clr_lim",  32'(at_limit), 32'h3);
    check_eq("clr_ovl",  32'(overlap),  32'h0);
    step();
    check_eq("clr_ovl2", 32'(overlap),  32'h0);

    // ch0 moves left at half tick rate until its left limit
    dir = 4'b0001; step();
    pulse_tick();
    check_eq("l_t1", 32'(chan_out[7:0]), 32'(ch0_exp[0]));
    step();
    check_eq("l_notick", 32'(chan_out[7:0]), 32'h10);
    for (int i = 1; i < 8; i++) begin
      pulse_tick();
      check_eq($sformatf("l_t%0d", i + 1), 32'(chan_out[7:0]), 32'(ch0_exp[i]));
    end
    check_eq("l_lim",  32'(at_limit), 32'h3);
    check_eq("l_data", 32'(data_out), 32'h81);

    // ch1 right at right limit is blocked, no wrap
    dir = 4'b1000; step();
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      check_eq($sformatf("r_blk%0d", i), 32'(chan_out[15:8]), 32'h01);
    end
    // ch1 left; a direction change mid-count restarts the count
    dir = 4'b0100; step();
    pulse_tick();
    check_eq("r_l1", 32'(chan_out[15:8]), 32'h01);
    dir = 4'b1000; step();
    dir = 4'b0100; step();
    pulse_tick();
    check_eq("r_restart", 32'(chan_out[15:8]), 32'h01);
    pulse_tick();
    check_eq("r_step", 32'(chan_out[15:8]), 32'h02);
    check_eq("r_lim",  32'(at_limit[1]), 32'h0);

    // Overlap detect lags the registers by one cycle
    dir = 4'b0000; data_in = 8'h04; load_n = 2'b01; step(); load_n = 2'b11;
    check_eq("o_ld1", 32'(chan_out), 32'h0480);
    check_eq("o_ov0", 32'(overlap),  32'h0);
    load_n = 2'b10; step(); load_n = 2'b11;
    check_eq("o_ld0", 32'(chan_out), 32'h0404);
    check_eq("o_lag", 32'(overlap),  32'h0);
    step();
    check_eq("o_set", 32'(overlap),  32'h1);
    dir = 4'b0100; step();
    pulse_tick();
    pulse_tick();
    check_eq("o_mv",   32'(chan_out[15:8]), 32'h08);
    check_eq("o_hold", 32'(overlap), 32'h1);
    step();
    check_eq("o_clr",  32'(overlap), 32'h0);
    check_eq("o_lim",  32'(at_limit), 32'h2);

    // Same cycle: clear ch0 during a qualifying tick, load ch1
    dir = 4'b0001; step();
    pulse_tick();
    check_eq("s_pre", 32'(chan_out[7:0]), 32'h04);
    clear_n = 2'b10; load_n = 2'b01; data_in = 8'h02; tick = 1'b1;
    step();
    clear_n = 2'b11; load_n = 2'b11; tick = 1'b0;
    check_eq("s_chan", 32'(chan_out), 32'h0210);
    pulse_tick();
    check_eq("s_cnt0", 32'(chan_out[7:0]), 32'h10);
    pulse_tick();
    check_eq("s_cnt1", 32'(chan_out[7:0]), 32'h20);
    check_eq("s_ch1",  32'(chan_out[15:8]), 32'h02);

    // Async reset between ticks with ch0 counter at 1
    pulse_tick();
    check_eq("a_pre", 32'(chan_out[7:0]), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    check_eq("a_chan", 32'(chan_out), 32'h0);
    check_eq("a_data", 32'(data_out), 32'h0);
    check_eq("a_lim",  32'(at_limit), 32'h0);
    check_eq("a_ovl",  32'(overlap),  32'h0);
    step();
    rst_n = 1'b1;
    clear_n = 2'b10; step(); clear_n = 2'b11;
    check_eq("a_clr", 32'(chan_out), 32'h0010);
    pulse_tick();
    check_eq("a_t1", 32'(chan_out[7:0]), 32'h10);
    pulse_tick();
    check_eq("a_t2", 32'(chan_out[7:0]), 32'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
